// File: rtl/fmul_arbiter.sv
// fmul_arbiter
//   Round-robin arbiter that shares one pipelined FMUL between N requesters.
//   The winning requester's operands are registered onto the FMUL operand pins.
//   The winner's tag {vld,id} enters a shift register sized to the FMUL latency,
//   so each result is steered back to its owner as a one-cycle res_valid pulse.
//
// Ports
//   clk, RESET            clock, async active-high reset
//   issue_en              0 blocks new grants, in-flight ops still retire
//   req_valid/req_ready   per-requester handshake, req_ready is a one-hot grant
//   req_a, req_b          per-requester operands, slice i = [32i+31:32i]
//   fm_A_* / fm_B_*       registered FMUL operands
//   fm_*                  FMUL result pins
//   res_valid             one-hot result pulse to the owning requester
//   res_*                 shared result bus, zero when no result is valid
//   idle                  nothing granted and nothing in flight
module fmul_arbiter #(
  parameter int N        = 4,
  parameter int FMUL_LAT = 3,
  parameter int IDW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              RESET,
  input  logic              issue_en,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic              fm_A_sign,
  output logic [7:0]        fm_A_exp,
  output logic [22:0]       fm_A_frac,
  output logic              fm_B_sign,
  output logic [7:0]        fm_B_exp,
  output logic [22:0]       fm_B_frac,
  input  logic              fm_sign,
  input  logic [7:0]        fm_exp,
  input  logic [23:0]       fm_frac,
  input  logic              fm_error,
  input  logic              fm_overflow,
  output logic [N-1:0]      res_valid,
  output logic              res_sign,
  output logic [7:0]        res_exp,
  output logic [23:0]       res_frac,
  output logic              res_error,
  output logic              res_overflow,
  output logic [IDW-1:0]    res_id,
  output logic              idle
);

  localparam int CW = $clog2(FMUL_LAT+2);

  logic [IDW-1:0]              last_q, last_d;
  logic [31:0]                 opa_q, opa_d, opb_q, opb_d;
  // Tag stage 0 lines up with the operand register; stage FMUL_LAT lines up
  // with the FMUL result pins.
  logic [FMUL_LAT:0]           vld_pipe;
  logic [FMUL_LAT:0][IDW-1:0]  id_pipe;
  logic [CW-1:0]               cnt_q, cnt_d;

  logic                        gnt_any;
  logic [IDW-1:0]              gnt_id;
  logic                        out_vld;
  logic [IDW-1:0]              out_id;

  // Grant: first valid requester after last, scanning modulo N. Held off
  // during reset so the ready bits read zero while RESET is high.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_any = 1'b0;
    gnt_id  = '0;
    if (issue_en && !RESET) begin
      for (int k = 1; k <= N; k++) begin
        idx = (int'(last_q) + k) % N;
        if (!gnt_any && req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_id  = IDW'(idx);
        end
      end
    end
  end

  assign req_ready = gnt_any ? (N'(1) << gnt_id) : '0;

  always_comb begin
    opa_d  = '0;
    opb_d  = '0;
    last_d = last_q;
    if (gnt_any) begin
      opa_d  = req_a[int'(gnt_id)*32 +: 32];
      opb_d  = req_b[int'(gnt_id)*32 +: 32];
      last_d = gnt_id;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({gnt_any, out_vld})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      last_q   <= IDW'(N-1);
      opa_q    <= '0;
      opb_q    <= '0;
      vld_pipe <= '0;
      id_pipe  <= '0;
      cnt_q    <= '0;
    end else begin
      last_q   <= last_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      vld_pipe <= {vld_pipe[FMUL_LAT-1:0], gnt_any};
      id_pipe  <= {id_pipe[FMUL_LAT-1:0], gnt_any ? gnt_id : IDW'(0)};
      cnt_q    <= cnt_d;
    end
  end

  assign {fm_A_sign, fm_A_exp, fm_A_frac} = opa_q;
  assign {fm_B_sign, fm_B_exp, fm_B_frac} = opb_q;

  // The FMUL's internal registers are never flushed, so everything on the
  // result bus is qualified by the last tag stage.
  assign out_vld      = vld_pipe[FMUL_LAT];
  assign out_id       = id_pipe[FMUL_LAT];
  assign res_valid    = out_vld ? (N'(1) << out_id) : '0;
  assign res_id       = out_vld ? out_id : '0;
  assign res_sign     = out_vld & fm_sign;
  assign res_exp      = out_vld ? fm_exp  : '0;
  assign res_frac     = out_vld ? fm_frac : '0;
  assign res_error    = out_vld & fm_error;
  assign res_overflow = out_vld & fm_overflow;

  assign idle = (cnt_q == '0) && (req_ready == '0);

endmodule

// File: tb/tb_fmul_arbiter.sv
module tb_fmul_arbiter;
  localparam int N   = 4;
  localparam int LAT = 3;
  localparam int IDW = $clog2(N);

  logic            clk = 1'b0;
  logic            RESET;
  logic            issue_en;
  logic [N-1:0]    req_valid, req_ready, res_valid;
  logic [N*32-1:0] req_a, req_b;
  logic            fm_A_sign, fm_B_sign;
  logic [7:0]      fm_A_exp, fm_B_exp;
  logic [22:0]     fm_A_frac, fm_B_frac;
  logic            fm_sign, fm_error, fm_overflow;
  logic [7:0]      fm_exp;
  logic [23:0]     fm_frac;
  logic            res_sign, res_error, res_overflow, idle;
  logic [7:0]      res_exp;
  logic [23:0]     res_frac;
  logic [IDW-1:0]  res_id;

  always #5 clk = ~clk;

  fmul_arbiter #(.N(N), .FMUL_LAT(LAT)) dut (
    .clk(clk), .RESET(RESET), .issue_en(issue_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .fm_A_sign(fm_A_sign), .fm_A_exp(fm_A_exp), .fm_A_frac(fm_A_frac),
    .fm_B_sign(fm_B_sign), .fm_B_exp(fm_B_exp), .fm_B_frac(fm_B_frac),
    .fm_sign(fm_sign), .fm_exp(fm_exp), .fm_frac(fm_frac),
    .fm_error(fm_error), .fm_overflow(fm_overflow),
    .res_valid(res_valid), .res_sign(res_sign), .res_exp(res_exp),
    .res_frac(res_frac), .res_error(res_error), .res_overflow(res_overflow),
    .res_id(res_id), .idle(idle)
  );

  // Behavioural FMUL: {sign, exp[7:0], frac[23:0], error, overflow}
  function automatic logic [34:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] p;
    int          e;
    logic [23:0] f;
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin f = p[47:24]; e = e + 1; end
    else       f = p[46:23];
    return {a[31] ^ b[31], e[7:0], f, (a[30:23] == 8'hff) || (b[30:23] == 8'hff), e > 254};
  endfunction

  // FMUL pipeline: result for operands held in cycle c is on the pins in c+LAT.
  logic [34:0] fp [1:LAT];
  always @(posedge clk) begin
    fp[1] <= fmul_ref({fm_A_sign, fm_A_exp, fm_A_frac}, {fm_B_sign, fm_B_exp, fm_B_frac});
    for (int k = 2; k <= LAT; k++) fp[k] <= fp[k-1];
  end
  assign {fm_sign, fm_exp, fm_frac, fm_error, fm_overflow} = fp[LAT];

  typedef struct {
    int          due;
    int          id;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0, nerr = 0, cyc = 0, npulse = 0;
  int          mlast = N-1;
  logic [31:0] pa = '0, pb = '0;
  logic [7:0]  obs_exp;
  logic [23:0] obs_frac;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  // One clock: check everything at the negedge against the model, then commit
  // the modelled grant and return just after the next rising edge.
  task automatic tick();
    int          g, i;
    logic [34:0] e;
    exp_t        x;
    @(negedge clk);
    if (RESET) begin sb.delete(); mlast = N-1; pa = '0; pb = '0; end
    g = -1;
    if (issue_en && !RESET)
      for (int k = 1; k <= N; k++) begin
        i = (mlast + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    chk("req_ready", req_ready, (g < 0) ? 0 : (N'(1) << g));
    chk("idle", idle, (sb.size() == 0) && (g < 0));
    chk("count", dut.cnt_q, sb.size());
    chk("count_bound", dut.cnt_q <= LAT+1, 1);
    chk("fm_A", {fm_A_sign, fm_A_exp, fm_A_frac}, pa);
    chk("fm_B", {fm_B_sign, fm_B_exp, fm_B_frac}, pb);
    if (res_valid != 0) npulse++;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = fmul_ref(sb[0].a, sb[0].b);
      chk("res_valid", res_valid, N'(1) << sb[0].id);
      chk("res_id", res_id, sb[0].id);
      chk("res_bus", {res_sign, res_exp, res_frac, res_error, res_overflow}, e);
      obs_exp  = res_exp;
      obs_frac = res_frac;
      void'(sb.pop_front());
    end else begin
      chk("res_valid_idle", res_valid, 0);
      chk("res_bus_idle", {res_sign, res_exp, res_frac, res_error, res_overflow, res_id}, 0);
    end
    if (g >= 0) begin
      x.due = cyc + 1 + LAT;
      x.id  = g;
      x.a   = req_a[g*32 +: 32];
      x.b   = req_b[g*32 +: 32];
      sb.push_back(x);
      pa = x.a; pb = x.b; mlast = g;
    end else begin
      pa = '0; pb = '0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
  endtask

  int p0;

  initial begin
    RESET = 1'b1; issue_en = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    tick();
    RESET = 1'b0;
    tick();

    // Single op from requester 1: 2.0 * 3.0
    req_valid = 4'b0010;
    req_a[63:32] = 32'h4000_0000;
    req_b[63:32] = 32'h4040_0000;
    obs_exp = '0; obs_frac = '0; p0 = npulse;
    tick();
    req_valid = '0;
    repeat (6) tick();
    chk("single_exp", obs_exp, 129);
    chk("single_frac", obs_frac, 24'hC00000);
    chk("single_pulses", npulse - p0, 1);

    // All four continuously from reset
    RESET = 1'b1; tick(); RESET = 1'b0;
    rand_ops(); req_valid = 4'b1111;
    repeat (12) begin tick(); rand_ops(); end
    req_valid = '0;
    repeat (6) tick();

    // Requesters 0 and 2 with last = 0
    req_valid = 4'b0001; tick();
    req_valid = 4'b0101; rand_ops(); tick(); tick();
    req_valid = '0;
    repeat (6) tick();

    // issue_en low for cycles 2..5
    req_valid = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      issue_en = !(c >= 2 && c <= 5);
      rand_ops();
      tick();
    end
    issue_en = 1'b1; req_valid = '0;
    repeat (6) tick();

    // Reset mid-flight: grants in cycles 0,1, reset in cycle 2
    p0 = npulse;
    req_valid = 4'b0001; rand_ops(); tick(); tick();
    req_valid = '0; RESET = 1'b1; tick();
    RESET = 1'b0;
    repeat (6) tick();
    chk("reset_drop_pulses", npulse - p0, 0);

    // Random traffic
    for (int c = 0; c < 10000; c++) begin
      req_valid = N'($urandom);
      issue_en  = ($urandom_range(0, 7) != 0);
      RESET     = ($urandom_range(0, 499) == 0);
      rand_ops();
      tick();
    end
    RESET = 1'b0; req_valid = '0; issue_en = 1'b1;
    repeat (8) tick();
    chk("drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
